// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control unit: sequences FETCH/DECODE/EXEC/MEM/WB for a
// subset of the instruction set. It also counts retired instructions and
// drops into a sticky TRAP state on illegal opcodes or memory timeouts.
module multicycle_control #(
    parameter int OP_W        = 11,
    parameter int ENABLE_IMM  = 1,
    parameter int ENABLE_CBNZ = 1,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [OP_W-1:0]  op_code,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             InstrRead,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             Mem2Reg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             UnconBranch,
    output logic [1:0]       ALU_op,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ILLEGAL,
        C_RTYPE,
        C_IMM,
        C_LOAD,
        C_STORE,
        C_CBZ,
        C_CBNZ,
        C_BRANCH
    } iclass_t;

    localparam logic [1:0] ALU_ADDR = 2'b00;
    localparam logic [1:0] ALU_PASS = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    // The last wait cycle that may still succeed; one more idle cycle traps.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     cur_state;
    state_t     next_state;
    iclass_t    iclass;
    logic [10:0] opc;
    logic [7:0] wait_cnt;
    logic       timed_out;
    logic       count_wait;
    logic       retire;

    // Only the eleven most significant opcode bits take part in decoding.
    assign opc       = op_code[OP_W-1 -: 11];
    assign timed_out = (wait_cnt == WAIT_LAST);
    assign state     = cur_state;
    assign trap      = (cur_state == TRAP);

    // Classify the opcode; optional instructions fall back to illegal when disabled.
    always_comb begin
        iclass = C_ILLEGAL;
        casez (opc)
            11'b11111000010: iclass = C_LOAD;
            11'b11111000000: iclass = C_STORE;
            11'b10110100???: iclass = C_CBZ;
            11'b10110101???: begin
                if (ENABLE_CBNZ != 0) begin
                    iclass = C_CBNZ;
                end
            end
            11'b000101?????: iclass = C_BRANCH;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000,
            11'b11010011011,
            11'b11010011010: iclass = C_RTYPE;
            11'b1001000100?,
            11'b1101000100?: begin
                if (ENABLE_IMM != 0) begin
                    iclass = C_IMM;
                end
            end
            default: iclass = C_ILLEGAL;
        endcase
    end

    // Next-state and control-output decode; everything is forced low while reset is held.
    always_comb begin
        next_state  = cur_state;
        InstrRead   = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Reg2Loc     = 1'b0;
        ALUSrc      = 1'b0;
        Mem2Reg     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        Branch      = 1'b0;
        UnconBranch = 1'b0;
        ALU_op      = ALU_ADDR;
        count_wait  = 1'b0;
        retire      = 1'b0;

        if (reset_n) begin
            case (cur_state)
                FETCH: begin
                    InstrRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        PCWrite    = 1'b1;
                        next_state = DECODE;
                    end else if (timed_out) begin
                        next_state = TRAP;
                    end else begin
                        count_wait = 1'b1;
                    end
                end

                DECODE: begin
                    Reg2Loc = (iclass == C_STORE) || (iclass == C_CBZ) || (iclass == C_CBNZ);
                    next_state = (iclass == C_ILLEGAL) ? TRAP : EXEC;
                end

                EXEC: begin
                    case (iclass)
                        C_RTYPE: begin
                            ALU_op     = ALU_FUNC;
                            next_state = WB;
                        end
                        C_IMM: begin
                            ALU_op     = ALU_FUNC;
                            ALUSrc     = 1'b1;
                            next_state = WB;
                        end
                        C_LOAD: begin
                            ALU_op     = ALU_ADDR;
                            ALUSrc     = 1'b1;
                            next_state = MEM;
                        end
                        C_STORE: begin
                            ALU_op     = ALU_ADDR;
                            ALUSrc     = 1'b1;
                            Reg2Loc    = 1'b1;
                            next_state = MEM;
                        end
                        C_CBZ: begin
                            ALU_op     = ALU_PASS;
                            Reg2Loc    = 1'b1;
                            Branch     = 1'b1;
                            PCWrite    = zero;
                            next_state = FETCH;
                            retire     = 1'b1;
                        end
                        C_CBNZ: begin
                            ALU_op     = ALU_PASS;
                            Reg2Loc    = 1'b1;
                            Branch     = 1'b1;
                            PCWrite    = !zero;
                            next_state = FETCH;
                            retire     = 1'b1;
                        end
                        C_BRANCH: begin
                            UnconBranch = 1'b1;
                            PCWrite     = 1'b1;
                            next_state  = FETCH;
                            retire      = 1'b1;
                        end
                        default: begin
                            next_state = TRAP;
                        end
                    endcase
                end

                MEM: begin
                    ALU_op = ALU_ADDR;
                    ALUSrc = 1'b1;
                    if (iclass == C_STORE) begin
                        MemWrite = 1'b1;
                        Reg2Loc  = 1'b1;
                    end else if (iclass == C_LOAD) begin
                        MemRead = 1'b1;
                    end

                    if ((iclass != C_STORE) && (iclass != C_LOAD)) begin
                        next_state = TRAP;
                    end else if (mem_ready) begin
                        if (iclass == C_STORE) begin
                            next_state = FETCH;
                            retire     = 1'b1;
                        end else begin
                            next_state = WB;
                        end
                    end else if (timed_out) begin
                        next_state = TRAP;
                    end else begin
                        count_wait = 1'b1;
                    end
                end

                WB: begin
                    RegWrite   = 1'b1;
                    Mem2Reg    = (iclass == C_LOAD);
                    next_state = FETCH;
                    retire     = 1'b1;
                end

                TRAP: begin
                    next_state = TRAP;
                end

                default: begin
                    next_state = TRAP;
                end
            endcase
        end
    end

    // State register; TRAP only exits through reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Memory wait counter: restarts whenever a wait ends or a new wait state is entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (count_wait) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Retired-instruction counter, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_W, default 11: opcode field width; opcode patterns are the 11 MSBs of the instruction; bits below [OP_W-1:OP_W-11] are ignored.
REQ-002 Parameter ENABLE_IMM, default 1: 1 = ADDI (1001000100?) and SUBI (1101000100?) are legal.
REQ-003 Parameter ENABLE_CBNZ, default 1: 1 = CBNZ (10110101???) is legal.
REQ-004 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ready (range 1..255).
REQ-005 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-006 clk  in  1  single clock, all state updates on the rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 op_code  in  OP_W  opcode from the instruction register; stable from DECODE until the next FETCH.
REQ-009 zero  in  1  ALU zero flag, sampled in EXEC.
REQ-010 mem_ready  in  1  memory completion strobe for the instruction fetch or data access.
REQ-011 Outputs (1 bit each, combinational from state/op_code/zero/mem_ready): InstrRead, IRWrite, PCWrite, Reg2Loc, ALUSrc, Mem2Reg, RegWrite, MemRead, MemWrite, Branch, UnconBranch.
REQ-012 ALU_op  out  2  00 = address add, 01 = pass/compare, 10 = R-type/immediate function.
REQ-013 state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-014 trap  out  1  sticky error flag; retired  out  CNT_W  retired-instruction count.

Function
REQ-015 FETCH: InstrRead=1; when mem_ready=1: IRWrite=1, PCWrite=1 (PC+4), next state DECODE; otherwise hold.
REQ-016 DECODE: all outputs 0 except Reg2Loc (1 for STUR/CBZ/CBNZ); next state EXEC if the opcode is legal, else TRAP.
REQ-017 Legal set: LDUR, STUR, CBZ, ADD, SUB, AND, ORR, LSL, LSR, B, plus ADDI/SUBI and CBNZ when enabled; disabled opcodes are illegal.
REQ-018 EXEC, R-type: ALU_op=10, ALUSrc=0; next state WB.
REQ-019 EXEC, ADDI/SUBI: ALU_op=10, ALUSrc=1; next state WB.
REQ-020 EXEC, LDUR/STUR: ALU_op=00, ALUSrc=1; next state MEM.
REQ-021 EXEC, CBZ: ALU_op=01, Reg2Loc=1, Branch=1; PCWrite=zero; RegWrite=0; next state FETCH; retires.
REQ-022 EXEC, CBNZ: as CBZ, with PCWrite=!zero.
REQ-023 EXEC, B: UnconBranch=1, PCWrite=1, RegWrite=0; next state FETCH; retires.
REQ-024 MEM: LDUR holds MemRead=1 and STUR holds MemWrite=1 (Reg2Loc=1, ALUSrc=1) until mem_ready=1; then LDUR goes to WB and STUR goes to FETCH and retires.
REQ-025 WB: RegWrite=1 for exactly one cycle; Mem2Reg=1 for LDUR only; next state FETCH; retires.
REQ-026 Wait counter: cleared on entry to FETCH/MEM; increments each cycle mem_ready=0 in FETCH or MEM; reaching TIMEOUT without mem_ready goes to TRAP.
REQ-027 mem_ready on the same cycle the counter reaches TIMEOUT counts as success, not trap.
REQ-028 mem_ready outside FETCH/MEM is ignored.
REQ-029 TRAP: trap=1, all control outputs 0; remain until reset.
REQ-030 retired increments by 1 on each retiring transition and wraps from 2^CNT_W-1 to 0.
REQ-031 Write-enables (PCWrite, IRWrite, RegWrite, MemWrite) never assert outside the states listed above.

Reset
REQ-032 reset_n=0 immediately forces state=FETCH, trap=0, retired=0, wait counter=0, all control outputs 0 while asserted, irrespective of clk.
REQ-033 Reset asserted mid-instruction (any state, including a pending MEM write) abandons it with no further write-enable; first cycle after release is FETCH with InstrRead=1.

Verification
REQ-034 ADD with mem_ready=1 in FETCH -> states 0,1,2,4,0; RegWrite high only in WB; retired=1.
REQ-035 LDUR, mem_ready delayed 3 cycles in MEM -> MemRead held 4 cycles, Mem2Reg=RegWrite=1 in WB; retired +1.
REQ-036 CBZ zero=1 then CBNZ zero=1 -> PCWrite=1 in EXEC for CBZ, 0 for CBNZ; RegWrite never high; retired +2.
REQ-037 STUR, mem_ready never asserted, TIMEOUT=15 -> TRAP after 15 wait cycles; MemWrite drops; trap=1 until reset_n=0.
REQ-038 ENABLE_CBNZ=0, opcode 10110101000 -> DECODE to TRAP; retired unchanged.
REQ-039 CNT_W=4, 16 consecutive B instructions -> retired wraps 15 to 0; reset_n pulsed in MEM -> state=0, outputs 0 asynchronously.
